// File: rtl/alu_arb_pkg.sv
// ---------------------------------------------------------------------------
// alu_arb_pkg -- shared types, constants and arithmetic helpers for the
// arbitrated ALU (alu_arb) and its datapath (alu_arb_dp).
//
// Contents:
//   OPW, RW      operand width (18) and result width (24)
//   state_e      arbiter FSM states
//   op_t         one captured operation
//   ext_op       18->24 bit sign/zero extension
//   alu_result   A +/- B + (cinsel ? cin : 0), modulo 2^24
//   alu_ovf      signed overflow flag (only when ALU_ARB_OVF_EN is defined)
// ---------------------------------------------------------------------------
package alu_arb_pkg;

  localparam int OPW = 18;
  localparam int RW  = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARB    = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic           signed_a;
    logic           signed_b;
    logic           addnsub;
    logic           cinsel;
    logic [RW-1:0]  cin;
  } op_t;

  function automatic logic [RW-1:0] ext_op(input logic [OPW-1:0] v, input logic s);
    return s ? {{(RW-OPW){v[OPW-1]}}, v} : {{(RW-OPW){1'b0}}, v};
  endfunction

  function automatic logic [RW-1:0] alu_result(input op_t op);
    logic [RW-1:0] a;
    logic [RW-1:0] b;
    logic [RW-1:0] c;
    a = ext_op(op.a, op.signed_a);
    b = ext_op(op.b, op.signed_b);
    c = op.cinsel ? op.cin : '0;
    return op.addnsub ? (a - b + c) : (a + b + c);
  endfunction

`ifdef ALU_ARB_OVF_EN
  // The three-term sum of 24-bit signed values always fits in 26 bits, so the
  // exact result is computed at that width; overflow means the top three bits
  // of the exact result are not all copies of the 24-bit sign bit.
  function automatic logic alu_ovf(input op_t op);
    logic [RW-1:0]  a;
    logic [RW-1:0]  b;
    logic [RW-1:0]  c;
    logic [RW+1:0]  wa;
    logic [RW+1:0]  wb;
    logic [RW+1:0]  wc;
    logic [RW+1:0]  w;
    a  = ext_op(op.a, op.signed_a);
    b  = ext_op(op.b, op.signed_b);
    c  = op.cinsel ? op.cin : '0;
    wa = {{2{a[RW-1]}}, a};
    wb = {{2{b[RW-1]}}, b};
    wc = {{2{c[RW-1]}}, c};
    w  = op.addnsub ? (wa - wb + wc) : (wa + wb + wc);
    return op.signed_a & op.signed_b &
           (w[RW+1:RW-1] != 3'b000) & (w[RW+1:RW-1] != 3'b111);
  endfunction
`endif

endpackage

// File: rtl/alu_arb_dp.sv
// ---------------------------------------------------------------------------
// alu_arb_dp -- arithmetic plus LAT-deep result/tag pipeline for alu_arb.
//
// The operation is evaluated on the transfer cycle and only the result and
// requester tag travel down the pipe, so later changes on the requester
// inputs cannot disturb results already in flight.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid           an operation transfers this cycle
//   in_id              index of the requester that transferred
//   in_op              the transferred operation
//   out_valid/id/r     result, exactly LAT cycles after the transfer
//   out_ovf            signed overflow flag (only with ALU_ARB_OVF_EN)
//
// Configuration macro: ALU_ARB_OVF_EN adds the overflow flag path.
// ---------------------------------------------------------------------------
module alu_arb_dp
  import alu_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int LAT  = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [IDW-1:0] in_id,
  input  op_t            in_op,
  output logic           out_valid,
  output logic [IDW-1:0] out_id,
  output logic [RW-1:0]  out_r
`ifdef ALU_ARB_OVF_EN
  ,
  output logic           out_ovf
`endif
);

  logic           vld_q [LAT];
  logic [IDW-1:0] id_q  [LAT];
  logic [RW-1:0]  r_q   [LAT];
  logic [RW-1:0]  r_new;

  assign r_new = alu_result(in_op);

  // Tag and result are zeroed on idle cycles so the outputs read 0 whenever
  // out_valid is low.
  // NOTE: every stage is reset, not just the valids: the last stage drives the
  // outputs directly and those must read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) begin
        vld_q[s] <= 1'b0;
        id_q[s]  <= '0;
        r_q[s]   <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make every stage read the pre-edge
      // value of the previous one, which is what makes this a shift register.
      vld_q[0] <= in_valid;
      id_q[0]  <= in_valid ? in_id : '0;
      r_q[0]   <= in_valid ? r_new : '0;
      for (int s = 1; s < LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        id_q[s]  <= id_q[s-1];
        r_q[s]   <= r_q[s-1];
      end
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_id    = id_q[LAT-1];
  assign out_r     = r_q[LAT-1];

`ifdef ALU_ARB_OVF_EN
  logic ovf_q [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) ovf_q[s] <= 1'b0;
    end else begin
      ovf_q[0] <= in_valid & alu_ovf(in_op);
      for (int s = 1; s < LAT; s++) ovf_q[s] <= ovf_q[s-1];
    end
  end

  assign out_ovf = ovf_q[LAT-1];
`endif

endmodule

// File: rtl/alu_arb.sv
// ---------------------------------------------------------------------------
// alu_arb -- NREQ requesters share one 24-bit adder/subtractor through a
// round-robin arbiter with optional burst locking.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid  [NREQ]      requester has an operation
//   req_ready  [NREQ]      one-hot grant (combinational from req_valid + state)
//   req_lock   [NREQ]      keep the grant after this operation
//   req_a/req_b [NREQ*18]  operands, requester i in bits [i*18 +: 18]
//   req_signed_a/b [NREQ]  sign-extend operand A/B
//   req_addnsub [NREQ]     0: A+B, 1: A-B
//   req_cinsel [NREQ]      add req_cin when 1
//   req_cin [NREQ*24]      cascade input, requester i in bits [i*24 +: 24]
//   rsp_valid/id/r         result, LAT cycles after the transfer
//   rsp_ovf                signed overflow flag (only with ALU_ARB_OVF_EN)
//
// Configuration macro: ALU_ARB_OVF_EN adds the rsp_ovf output.
// ---------------------------------------------------------------------------
module alu_arb
  import alu_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int LAT       = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_lock,
  input  logic [NREQ*OPW-1:0]     req_a,
  input  logic [NREQ*OPW-1:0]     req_b,
  input  logic [NREQ-1:0]         req_signed_a,
  input  logic [NREQ-1:0]         req_signed_b,
  input  logic [NREQ-1:0]         req_addnsub,
  input  logic [NREQ-1:0]         req_cinsel,
  input  logic [NREQ*RW-1:0]      req_cin,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [RW-1:0]           rsp_r
`ifdef ALU_ARB_OVF_EN
  ,
  output logic                    rsp_ovf
`endif
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = 4;

  state_e         state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] owner_q;
  logic [CW-1:0]  cnt_q;

  // Unpack the flat operand buses into one struct per requester.
  op_t req_ops [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_ops[i] = '{
      a:        req_a[i*OPW +: OPW],
      b:        req_b[i*OPW +: OPW],
      signed_a: req_signed_a[i],
      signed_b: req_signed_b[i],
      addnsub:  req_addnsub[i],
      cinsel:   req_cinsel[i],
      cin:      req_cin[i*RW +: RW]
    };
  end

  // Round-robin search from ptr_q upward with wrap. Scanning offsets from the
  // far end down lets the nearest valid requester win without a break.
  logic [IDW-1:0] rr_idx;
  logic           rr_found;
  logic [IDW:0]   cand_sum;
  logic [IDW-1:0] cand_idx;

  // NOTE: every variable gets a default before the loop; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    cand_sum = '0;
    cand_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(NREQ)) cand_sum = cand_sum - (IDW+1)'(NREQ);
      cand_idx = cand_sum[IDW-1:0];
      if (req_valid[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  // While locked and the owner is valid only the owner is served. If the
  // owner drops req_valid the lock ends this very cycle and the round-robin
  // search grants someone else immediately, so no cycle is lost.
  logic           owner_hold;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;

  assign owner_hold = (state_q == ST_LOCKED) && req_valid[owner_q];
  assign gnt_any    = owner_hold | rr_found;
  assign gnt_idx    = owner_hold ? owner_q : rr_idx;
  assign req_ready  = gnt_any ? (NREQ'(1) << gnt_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else if (owner_hold) begin
      // Owner transfer; it completes even on the cycle that ends the lock.
      if (!req_lock[owner_q] || (int'(cnt_q) + 1 >= MAX_BURST)) begin
        state_q <= ST_ARB;
        cnt_q   <= '0;
      end else begin
        cnt_q   <= cnt_q + 1'b1;
      end
    end else if (rr_found) begin
      ptr_q <= (rr_idx == IDW'(NREQ - 1)) ? '0 : rr_idx + 1'b1;
      // With MAX_BURST of 1 the first locked transfer already exhausts the
      // burst, so the lock is never entered.
      if (req_lock[rr_idx] && MAX_BURST > 1) begin
        state_q <= ST_LOCKED;
        owner_q <= rr_idx;
        cnt_q   <= CW'(1);
      end else begin
        state_q <= ST_ARB;
        cnt_q   <= '0;
      end
    end else begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end
  end

  alu_arb_dp #(
    .NREQ (NREQ),
    .LAT  (LAT)
  ) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (gnt_any),
    .in_id     (gnt_idx),
    .in_op     (req_ops[gnt_idx]),
    .out_valid (rsp_valid),
    .out_id    (rsp_id),
    .out_r     (rsp_r)
`ifdef ALU_ARB_OVF_EN
    ,
    .out_ovf   (rsp_ovf)
`endif
  );

endmodule

// File: tb/tb_alu_arb.sv
// ---------------------------------------------------------------------------
// tb_alu_arb -- directed self-checking bench for alu_arb (NREQ=4, LAT=2,
// MAX_BURST=4). Inputs change just after the falling edge and outputs are
// sampled 2 time units later, well before the next rising edge.
// With ALU_ARB_OVF_EN defined the overflow flag is checked as well.
// ---------------------------------------------------------------------------
module tb_alu_arb;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [3:0]  req_lock;
  logic [71:0] req_a;
  logic [71:0] req_b;
  logic [3:0]  req_signed_a;
  logic [3:0]  req_signed_b;
  logic [3:0]  req_addnsub;
  logic [3:0]  req_cinsel;
  logic [95:0] req_cin;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [23:0] rsp_r;
`ifdef ALU_ARB_OVF_EN
  logic        rsp_ovf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arb #(
    .NREQ      (4),
    .LAT       (2),
    .MAX_BURST (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_lock     (req_lock),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_signed_a (req_signed_a),
    .req_signed_b (req_signed_b),
    .req_addnsub  (req_addnsub),
    .req_cinsel   (req_cinsel),
    .req_cin      (req_cin),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_r        (rsp_r)
`ifdef ALU_ARB_OVF_EN
    ,
    .rsp_ovf      (rsp_ovf)
`endif
  );

  task automatic clear_inputs();
    req_valid    = '0;
    req_lock     = '0;
    req_a        = '0;
    req_b        = '0;
    req_signed_a = '0;
    req_signed_b = '0;
    req_addnsub  = '0;
    req_cinsel   = '0;
    req_cin      = '0;
  endtask

  task automatic set_op(input int i, input logic [17:0] a, input logic [17:0] b,
                        input logic sa, input logic sb, input logic sub,
                        input logic cs, input logic [23:0] cin);
    req_a[i*18 +: 18] = a;
    req_b[i*18 +: 18] = b;
    req_signed_a[i]   = sa;
    req_signed_b[i]   = sb;
    req_addnsub[i]    = sub;
    req_cinsel[i]     = cs;
    req_cin[i*24 +: 24] = cin;
  endtask

  // Leaves the bench at a falling edge with reset released and inputs idle.
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Requester i computes (i+1) + 0x10 = 0x11 + i.
  task automatic load_rr_ops();
    for (int i = 0; i < NREQ; i++) set_op(i, 18'(i + 1), 18'h10, 0, 0, 0, 0, 24'h0);
  endtask

  task automatic test_reset();
    apply_reset();
    #2;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_r !== 24'h0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b id=%0d r=%h exp 0/0/000000", rsp_valid, rsp_id, rsp_r);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    int         exp_id;
    apply_reset();
    load_rr_ops();
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #2;
      exp_rdy = 4'b0001 << (k % 4);
      checks++;
      if (req_ready !== exp_rdy) begin
        failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, req_ready, exp_rdy);
      end
      if (k >= 2) begin
        exp_id = (k - 2) % 4;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id) || rsp_r !== 24'(8'h11 + exp_id)) begin
          failures++;
          $display("FAIL rr_rsp[%0d] got valid=%b id=%0d r=%h exp 1/%0d/%h",
                   k, rsp_valid, rsp_id, rsp_r, exp_id, 24'(8'h11 + exp_id));
        end
      end else begin
        checks++;
        if (rsp_valid !== 1'b0) begin
          failures++; $display("FAIL rr_early_rsp[%0d] got=%b exp=0", k, rsp_valid);
        end
      end
    end
    req_valid = '0;
  endtask

  task automatic test_arith();
    apply_reset();
    set_op(1, 18'h3FFFF, 18'h00001, 1, 0, 1, 1, 24'h000010);
    req_valid = 4'b0010;
    #2;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL arith_grant got=%b exp=0010", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    set_op(1, 18'h12345, 18'h2AAAA, 0, 1, 0, 0, 24'hABCDEF);
    #2;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL arith_lat1 got valid=%b exp=0", rsp_valid);
    end
    @(negedge clk);
    #2;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_r !== 24'h00000E) begin
      failures++;
      $display("FAIL arith_rsp got valid=%b id=%0d r=%h exp 1/1/00000e", rsp_valid, rsp_id, rsp_r);
    end
    @(negedge clk);
    #2;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL arith_single got valid=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] va   [3] = '{18'h3FFFF, 18'h00000, 18'h20000};
    logic [17:0] vb   [3] = '{18'h3FFFF, 18'h20000, 18'h00005};
    logic        vsa  [3] = '{1'b0, 1'b0, 1'b1};
    logic        vsb  [3] = '{1'b0, 1'b1, 1'b0};
    logic        vsub [3] = '{1'b0, 1'b1, 1'b0};
    logic        vcs  [3] = '{1'b0, 1'b1, 1'b1};
    logic [23:0] vcin [3] = '{24'hFFFFFF, 24'hFFFFFF, 24'h000100};
    logic [23:0] vexp [3] = '{24'h07FFFE, 24'h01FFFF, 24'hFE0105};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 3) begin
        set_op(0, va[k], vb[k], vsa[k], vsb[k], vsub[k], vcs[k], vcin[k]);
        req_valid = 4'b0001;
      end else begin
        req_valid = 4'b0000;
      end
      #2;
      if (k < 3) begin
        checks++;
        if (req_ready !== 4'b0001) begin
          failures++; $display("FAIL b2b_grant[%0d] got=%b exp=0001", k, req_ready);
        end
      end
      if (k >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_r !== vexp[k-2]) begin
          failures++;
          $display("FAIL b2b_rsp[%0d] got valid=%b id=%0d r=%h exp 1/0/%h",
                   k, rsp_valid, rsp_id, rsp_r, vexp[k-2]);
        end
      end
    end
  endtask

  task automatic test_lock_burst();
    logic [3:0] exp_rdy [12] = '{4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                                 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b1000};
    apply_reset();
    load_rr_ops();
    req_valid = 4'hF;
    req_lock  = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      // Second lock is released after one extra owner transfer.
      if (k == 10) req_lock = 4'b0000;
      #2;
      checks++;
      if (req_ready !== exp_rdy[k]) begin
        failures++; $display("FAIL lock_grant[%0d] got=%b exp=%b", k, req_ready, exp_rdy[k]);
      end
    end
    req_valid = '0;
    req_lock  = '0;
  endtask

  task automatic test_owner_drop();
    logic [3:0] exp_rdy [6] = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    load_rr_ops();
    req_valid = 4'hF;
    req_lock  = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 3) req_valid = 4'b1101;
      #2;
      checks++;
      if (req_ready !== exp_rdy[k]) begin
        failures++; $display("FAIL drop_grant[%0d] got=%b exp=%b", k, req_ready, exp_rdy[k]);
      end
    end
    req_valid = '0;
    req_lock  = '0;
  endtask

  task automatic test_reset_inflight();
    apply_reset();
    load_rr_ops();
    req_valid = 4'hF;
    #2;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL rstf_grant0 got=%b exp=0001", req_ready);
    end
    @(negedge clk);
    #2;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL rstf_grant1 got=%b exp=0010", req_ready);
    end
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'b1100;
    #2;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_r !== 24'h0) begin
      failures++;
      $display("FAIL rstf_in_reset got valid=%b id=%0d r=%h exp 0/0/000000", rsp_valid, rsp_id, rsp_r);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    checks++;
    if (req_ready !== 4'b0100 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstf_after got ready=%b valid=%b exp 0100/0", req_ready, rsp_valid);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #2;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL rstf_flushed got valid=%b exp=0", rsp_valid);
    end
    @(negedge clk);
    #2;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_r !== 24'h000013) begin
      failures++;
      $display("FAIL rstf_new_rsp got valid=%b id=%0d r=%h exp 1/2/000013", rsp_valid, rsp_id, rsp_r);
    end
    @(negedge clk);
    #2;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL rstf_tail got valid=%b exp=0", rsp_valid);
    end
  endtask

`ifdef ALU_ARB_OVF_EN
  task automatic test_ovf();
    logic        vsa  [3] = '{1'b1, 1'b1, 1'b0};
    logic        vcs  [3] = '{1'b1, 1'b0, 1'b1};
    logic [23:0] vcin [3] = '{24'h7FFFFF, 24'h000000, 24'h7FFFFF};
    logic [23:0] vexp [3] = '{24'h83FFFD, 24'h03FFFE, 24'h83FFFD};
    logic        vovf [3] = '{1'b1, 1'b0, 1'b0};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 3) begin
        set_op(0, 18'h1FFFF, 18'h1FFFF, vsa[k], 1'b1, 1'b0, vcs[k], vcin[k]);
        req_valid = 4'b0001;
      end else begin
        req_valid = 4'b0000;
      end
      #2;
      if (k >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_r !== vexp[k-2] || rsp_ovf !== vovf[k-2]) begin
          failures++;
          $display("FAIL ovf_rsp[%0d] got valid=%b r=%h ovf=%b exp 1/%h/%b",
                   k, rsp_valid, rsp_r, rsp_ovf, vexp[k-2], vovf[k-2]);
        end
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_arith();
    test_back_to_back();
    test_lock_burst();
    test_owner_drop();
    test_reset_inflight();
`ifdef ALU_ARB_OVF_EN
    test_ovf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
